// File: rtl/cncompress_serial.sv
// Check-node compressor: folds one row of Wc messages into {min1, min2, idx, extrinsic signs}
// and presents it on a valid/ready output, with one extra row of buffering for backpressure.
module cncompress_serial #(
   parameter  int Wc        = 32,
   parameter  int Wcbits    = 5,
   parameter  int W         = 10,
   localparam int ECOMPSIZE = 2*(W-1)+Wcbits+Wc
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [W-1:0]         Lq,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [ECOMPSIZE-1:0] Ecomp,
   output logic                 out_valid,
   input  logic                 out_ready
);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t               r_state, w_state_n;
   logic [Wcbits-1:0]    r_cnt;
   logic [W-2:0]         r_min1, r_min2;
   logic [Wcbits-1:0]    r_idx;
   logic [Wc-1:0]        r_signs;
   logic                 r_par;
   logic [ECOMPSIZE-1:0] r_hold;
   logic [ECOMPSIZE-1:0] r_ecomp;
   logic                 r_out_valid;

   logic                 w_beat, w_last, w_slot_free;
   logic                 w_load_new, w_load_hold, w_to_hold;
   logic [W-1:0]         w_abs;
   logic [W-2:0]         w_mag;
   logic [W-2:0]         w_min1_n, w_min2_n;
   logic [Wcbits-1:0]    w_idx_n;
   logic [Wc-1:0]        w_signs_n;
   logic                 w_par_n;
   logic [ECOMPSIZE-1:0] w_row;

   assign in_ready  = (r_state == ACCUM);
   assign Ecomp     = r_ecomp;
   assign out_valid = r_out_valid;

   always_comb begin
      w_state_n   = r_state;
      w_beat      = in_valid && (r_state == ACCUM);
      w_last      = (r_cnt == Wcbits'(Wc-1));
      w_slot_free = !r_out_valid || out_ready;
      w_load_new  = 1'b0;
      w_load_hold = 1'b0;
      w_to_hold   = 1'b0;
      case (r_state)
         ACCUM: begin
            if (w_beat && w_last) begin
               if (w_slot_free) begin
                  w_load_new = 1'b1;
               end else begin
                  w_to_hold = 1'b1;
                  w_state_n = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               w_load_hold = 1'b1;
               w_state_n   = ACCUM;
            end
         end
         default: w_state_n = ACCUM;
      endcase
   end

   // Values after this beat; on the last beat they form the completed row directly.
   always_comb begin
      w_abs = Lq[W-1] ? -Lq : Lq;
      w_mag = w_abs[W-1] ? '1 : w_abs[W-2:0];
      w_min1_n = r_min1;
      w_min2_n = r_min2;
      w_idx_n  = r_idx;
      if (r_cnt == '0) begin
         w_min1_n = w_mag;
         w_min2_n = '1;
         w_idx_n  = '0;
      end else if (w_mag < r_min1) begin
         w_min2_n = r_min1;
         w_min1_n = w_mag;
         w_idx_n  = r_cnt;
      end else if (w_mag < r_min2) begin
         w_min2_n = w_mag;
      end
      w_signs_n        = r_signs;
      w_signs_n[r_cnt] = Lq[W-1];
      w_par_n          = (r_cnt == '0) ? Lq[W-1] : (r_par ^ Lq[W-1]);
      w_row            = {w_min1_n, w_min2_n, w_idx_n, w_signs_n ^ {Wc{w_par_n}}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ACCUM;
         r_cnt       <= '0;
         r_min1      <= '0;
         r_min2      <= '0;
         r_idx       <= '0;
         r_signs     <= '0;
         r_par       <= 1'b0;
         r_hold      <= '0;
         r_ecomp     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state <= w_state_n;
         if (w_beat) begin
            r_min1  <= w_min1_n;
            r_min2  <= w_min2_n;
            r_idx   <= w_idx_n;
            r_signs <= w_signs_n;
            r_par   <= w_par_n;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
         end
         if (w_to_hold) begin
            r_hold <= w_row;
         end
         if (w_load_new) begin
            r_ecomp     <= w_row;
            r_out_valid <= 1'b1;
         end else if (w_load_hold) begin
            r_ecomp     <= r_hold;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/cncompress_serial.md
Name: cncompress_serial

Overview:
- Check-node compressor stage of the LDPC decoder. Sits directly upstream of the compressed-message recovery stage.
- Consumes one row of Wc variable-to-check messages, one message per accepted beat.
- Produces the compressed word Ecomp: min1, min2, min1 index and the Wc updated signs, in the packing the recovery stage consumes.
- Holds the result with a valid/ready handshake so row accumulation overlaps downstream backpressure.

Parameters:
- Wc, 32, check-node degree (messages per row).
- Wcbits, 5, index width; ceil(log2(Wc)).
- W, 10, message width, two's complement.
- ECOMPSIZE, 2*(W-1)+Wcbits+Wc, compressed word width (derived; never overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- Lq  input  W  incoming message, two's complement.
- in_valid  input  1  Lq is valid this cycle.
- in_ready  output  1  block accepts Lq this cycle.
- Ecomp  output  ECOMPSIZE  compressed row: {min1[W-2:0], min2[W-2:0], idx[Wcbits-1:0], sign[Wc-1:0]}, min1 at MSB.
- out_valid  output  1  Ecomp holds a completed row.
- out_ready  input  1  downstream takes Ecomp this cycle.

Behaviour:
- Reset (rst=1 at an edge):
  - Ecomp=0, out_valid=0, row counter=0, accumulators cleared, state=ACCUM.
  - in_ready=1 from the first cycle after reset.
  - A partial row in progress is discarded.
  - Reset has priority over all other events.
- Beat rules:
  - A beat occurs when in_valid&&in_ready.
  - Beat k of a row is message index k, with k = row counter, 0..Wc-1.
  - The counter wraps from Wc-1 to 0 on the last beat.
  - Bubbles (in_valid=0) leave all state unchanged.
- Magnitude:
  - mag = |Lq| saturated to W-1 bits; -2^(W-1) maps to 2^(W-1)-1.
  - sgn = Lq[W-1].
- Min tracking:
  - k==0 loads min1=mag, min2=2^(W-1)-1, idx=0.
  - k>0 with mag<min1: min2=min1, min1=mag, idx=k.
  - k>0 with min1<=mag<min2: min2=mag.
  - Otherwise no change.
  - Comparisons are strict, so ties keep the earliest index as min1, and an equal value goes to min2.
- Signs:
  - sign_buf[k]=sgn on each beat.
  - parity = XOR of all sgn in the row, reset at k==0.
  - Output sign[i] = sign_buf[i] XOR parity, i.e. the extrinsic sign; bit 0 is message 0.
- States:
  - ACCUM: in_ready=1. On the last beat (k==Wc-1):
    - If slot free (out_valid==0 or out_ready==1 this cycle): load Ecomp from the final values, including this beat's contribution; out_valid=1 next cycle; stay ACCUM.
    - Else: latch the completed row internally; go HOLD.
  - HOLD: in_ready=0. When out_ready==1 (out_valid is necessarily 1): load Ecomp from the held row at that edge; out_valid stays 1; go ACCUM.
- Latency and throughput:
  - Latency: Ecomp valid 1 cycle after the last beat when the slot is free.
  - Sustained throughput: 1 row per Wc cycles.
- Output handshake:
  - out_valid falls only when out_ready==1 and no new row loads at the same edge.
  - Ecomp is stable while out_valid==1 and out_ready==0.
  - Simultaneous consume and load: the new row replaces the old with no gap cycle.
- No combinational path from out_ready to in_ready except the HOLD exit, which is registered; in_ready depends on state only.

Test Plan:
- Row with all messages +5, except msg7=-3 and msg20=+4 -> Ecomp fields min1=3, min2=4, idx=7, sign=0xFFFF_FF7F; out_valid 1 cycle after beat 31.
- All 32 messages =+9 (ties) -> min1=9, min2=9, idx=0, sign=0x0000_0000.
- All 32 messages =-512 -> min1=511, min2=511, idx=0, parity=0, sign=0xFFFF_FFFF (saturation check).
- out_ready=0; two rows streamed back-to-back ->
  - row1 held stable;
  - row2 fully accepted, then in_ready=0 from the cycle after row2's beat 31;
  - one-cycle out_ready pulse -> Ecomp switches to row2 next cycle with out_valid held 1, and in_ready=1 again.
- Reset asserted after 10 beats of a row, then the scenario-1 row sent -> output exactly the scenario-1 values; no stale sign or min leaks from the pre-reset beats.
- Scenario-1 row with random in_valid bubbles (about 50%) and random out_ready -> identical Ecomp; beat count per row is exactly 32.
